// File: rtl/collision_pkg.sv
// collision_pkg: shared box type, checker FSM states and T-rex inset constants.
// Contents: box_t (signed 12-bit corner, 10-bit size), coll_state_t, INSET_X/INSET_TOP, inset_box().
package collision_pkg;

    typedef struct packed {
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic        [9:0]  w;
        logic        [9:0]  h;
    } box_t;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} coll_state_t;

    localparam int INSET_X   = 4;
    localparam int INSET_TOP = 2;

    // Sprite-outline approximation; tiny boxes keep their full size so they never collapse.
    function automatic box_t inset_box(input box_t b);
        box_t r;
        r = b;
        if (b.w > 10'(2 * INSET_X) && b.h > 10'(INSET_TOP)) begin
            r.x = b.x + 12'(INSET_X);
            r.w = b.w - 10'(2 * INSET_X);
            r.y = b.y + 12'(INSET_TOP);
            r.h = b.h - 10'(INSET_TOP);
        end
        return r;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// box_overlap: combinational strict axis-aligned overlap test between two boxes.
// Ports: a, b (box_t) in; hit out, high when the interiors intersect (shared edges do not count).
module box_overlap
    import collision_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic hit
);

    logic signed [12:0] ax, ay, bx, by, ar, ab, br, bb;

    // 13-bit signed arithmetic: corner + zero-extended size cannot overflow.
    always_comb begin
        ax  = {a.x[11], a.x};
        ay  = {a.y[11], a.y};
        bx  = {b.x[11], b.x};
        by  = {b.y[11], b.y};
        ar  = ax + {3'b000, a.w};
        ab  = ay + {3'b000, a.h};
        br  = bx + {3'b000, b.w};
        bb  = by + {3'b000, b.h};
        hit = (ax < br) && (bx < ar) && (ay < bb) && (by < ab);
    end

endmodule

// File: rtl/trex_collision.sv
// trex_collision: per-tick scan of the obstacle table producing a sticky T-rex crash flag.
// Ports: clk, rst (sync, active high), update (tick), clear (restart), trex_x/y/w/h (T-rex box),
//        obs_req/obs_idx (table read strobe/slot), obs_valid/obs_x/y/w/h (slot data, one cycle later),
//        busy (scan in progress), done (scan-complete pulse), crash (sticky collision).
// Build option: define TREX_COLLISION_INSET_EN to shrink the latched T-rex box to its sprite outline.
module trex_collision
    import collision_pkg::*;
#(
    parameter int NUM_OBSTACLES = 3,
    parameter int IDX_W         = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    update,
    input  logic                    clear,
    input  logic signed [11:0]      trex_x,
    input  logic signed [11:0]      trex_y,
    input  logic        [9:0]       trex_w,
    input  logic        [9:0]       trex_h,
    output logic                    obs_req,
    output logic        [IDX_W-1:0] obs_idx,
    input  logic                    obs_valid,
    input  logic signed [11:0]      obs_x,
    input  logic signed [11:0]      obs_y,
    input  logic        [9:0]       obs_w,
    input  logic        [9:0]       obs_h,
    output logic                    busy,
    output logic                    done,
    output logic                    crash
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBSTACLES - 1);

    coll_state_t      state_q, state_d;
    box_t             trex_q, trex_d, trex_in, obs_box;
    logic             obs_hit;
    logic             obs_req_q, obs_req_d;
    logic [IDX_W-1:0] obs_idx_q, obs_idx_d;
    logic             rsp_q, rsp_d;
    logic             acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             crash_q, crash_d;

    assign trex_in = '{x: trex_x, y: trex_y, w: trex_w, h: trex_h};
    assign obs_box = '{x: obs_x, y: obs_y, w: obs_w, h: obs_h};

    box_overlap u_overlap (
        .a   (trex_q),
        .b   (obs_box),
        .hit (obs_hit)
    );

    // rsp_q marks a cycle whose obs_* inputs answer last cycle's request.
    always_comb begin
        state_d   = state_q;
        trex_d    = trex_q;
        obs_req_d = 1'b0;
        obs_idx_d = obs_idx_q;
        rsp_d     = obs_req_q;
        acc_d     = acc_q | (rsp_q & obs_valid & obs_hit);
        done_d    = 1'b0;
        crash_d   = crash_q;
        if (clear) begin
            state_d = IDLE;
            rsp_d   = 1'b0;
            acc_d   = 1'b0;
            crash_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (update) begin
                    state_d   = SCAN;
                    obs_req_d = 1'b1;
                    obs_idx_d = '0;
                    acc_d     = 1'b0;
`ifdef TREX_COLLISION_INSET_EN
                    trex_d    = inset_box(trex_in);
`else
                    trex_d    = trex_in;
`endif
                end
                SCAN: if (obs_idx_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    obs_req_d = 1'b1;
                    obs_idx_d = obs_idx_q + IDX_W'(1);
                end
                DRAIN: begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    crash_d = crash_q | acc_d;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            trex_q    <= '0;
            obs_req_q <= 1'b0;
            obs_idx_q <= '0;
            rsp_q     <= 1'b0;
            acc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crash_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            trex_q    <= trex_d;
            obs_req_q <= obs_req_d;
            obs_idx_q <= obs_idx_d;
            rsp_q     <= rsp_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            crash_q   <= crash_d;
        end
    end

    assign obs_req = obs_req_q;
    assign obs_idx = obs_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign crash   = crash_q;

endmodule

// File: tb/tb_trex_collision.sv
// tb_trex_collision: scoreboard bench for trex_collision with a registered obstacle-table model.
module tb_trex_collision;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              update = 1'b0;
    logic              clear = 1'b0;
    logic signed [11:0] trex_x = '0, trex_y = '0;
    logic        [9:0]  trex_w = '0, trex_h = '0;
    logic              obs_req;
    logic [2:0]        obs_idx;
    logic              obs_valid;
    logic signed [11:0] obs_x, obs_y;
    logic        [9:0]  obs_w, obs_h;
    logic              busy, done, crash;

    int  tx[8], ty[8], tw[8], th[8];
    bit  tv[8];
    int  idx_log[$];
    bit  exp_q[$];
    int  n_vec = 0, n_err = 0, done_cnt = 0;
    bit  crash_m = 1'b0;

    trex_collision #(.NUM_OBSTACLES(N), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .update(update), .clear(clear),
        .trex_x(trex_x), .trex_y(trex_y), .trex_w(trex_w), .trex_h(trex_h),
        .obs_req(obs_req), .obs_idx(obs_idx), .obs_valid(obs_valid),
        .obs_x(obs_x), .obs_y(obs_y), .obs_w(obs_w), .obs_h(obs_h),
        .busy(busy), .done(done), .crash(crash)
    );

    always #5 clk = ~clk;

    // Registered-read obstacle table: data answers the request one cycle later.
    always @(posedge clk) begin
        obs_valid <= obs_req && tv[obs_idx];
        obs_x     <= 12'(tx[obs_idx]);
        obs_y     <= 12'(ty[obs_idx]);
        obs_w     <= 10'(tw[obs_idx]);
        obs_h     <= 10'(th[obs_idx]);
    end

    always @(posedge clk) if (obs_req) idx_log.push_back(int'(obs_idx));
    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic bit ov(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic bit model_hit();
        int ax = int'(trex_x), ay = int'(trex_y), aw = int'(trex_w), ah = int'(trex_h);
        bit h = 1'b0;
`ifdef TREX_COLLISION_INSET_EN
        if (aw > 8 && ah > 2) begin
            ax += 4; aw -= 8; ay += 2; ah -= 2;
        end
`endif
        for (int s = 0; s < N; s++)
            if (tv[s] && ov(ax, ay, aw, ah, tx[s], ty[s], tw[s], th[s])) h = 1'b1;
        return h;
    endfunction

    task automatic set_trex(input int x, input int y, input int w, input int h);
        trex_x = 12'(x); trex_y = 12'(y); trex_w = 10'(w); trex_h = 10'(h);
    endtask

    task automatic set_slot(input int s, input bit v, input int x, input int y, input int w, input int h);
        tv[s] = v; tx[s] = x; ty[s] = y; tw[s] = w; th[s] = h;
    endtask

    task automatic empty_table();
        for (int s = 0; s < 8; s++) set_slot(s, 1'b0, 0, 0, 1, 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        crash_m = 1'b0;
        @(negedge clk);
    endtask

    // Pulses update and waits for done; lat is cycles after the sampling edge, -1 on timeout.
    task automatic run_scan(output int lat);
        bit h;
        h = model_hit();
        exp_q.push_back(crash_m | h);
        crash_m |= h;
        idx_log.delete();
        done_cnt = 0;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL reset_obs_req got %b want 0", obs_req); end
        n_vec++; if (obs_idx !== 3'd0) begin n_err++; $display("FAIL reset_obs_idx got %0d want 0", obs_idx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (crash !== 1'b0) begin n_err++; $display("FAIL reset_crash got %b want 0", crash); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        bit e, ok;
        empty_table();
        set_trex(50, 93, 44, 47);
        set_slot(1, 1'b1, 80, 110, 17, 35);
        run_scan(lat);
        e = exp_q.pop_front();
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency got %0d want 4", lat); end
        n_vec++; if (crash !== e) begin n_err++; $display("FAIL basic_crash got %b want %b", crash, e); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_at_done got %b want 1", busy); end
        ok = (idx_log.size() == N);
        for (int i = 0; i < idx_log.size(); i++) if (idx_log[i] != i) ok = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_idx_seq got %p want 0,1,2", idx_log); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL basic_idle_after got busy=%b done=%b want 0 0", busy, done); end
        do_clear();
    endtask

    task automatic test_edges();
        int xs[3] = '{94, 93, 92};
        int lat;
        bit e;
        for (int k = 0; k < 3; k++) begin
            empty_table();
            set_trex(50, 93, 44, 47);
            set_slot(2, 1'b1, xs[k], 110, 17, 35);
            run_scan(lat);
            e = exp_q.pop_front();
            n_vec++; if (lat !== 4) begin n_err++; $display("FAIL edge_x%0d_latency got %0d want 4", xs[k], lat); end
            n_vec++; if (crash !== e) begin n_err++; $display("FAIL edge_x%0d_crash got %b want %b", xs[k], crash, e); end
            @(negedge clk);
            do_clear();
        end
    endtask

    task automatic test_negative();
        int xs[2] = '{10, 24};
        int lat;
        bit e;
        for (int k = 0; k < 2; k++) begin
            empty_table();
            set_trex(-20, -10, 44, 47);
            set_slot(0, 1'b1, xs[k], 5, 5, 5);
            run_scan(lat);
            e = exp_q.pop_front();
            n_vec++; if (crash !== e) begin n_err++; $display("FAIL negative_x%0d_crash got %b want %b", xs[k], crash, e); end
            @(negedge clk);
            do_clear();
        end
    endtask

    task automatic test_invalid_slot();
        int lat;
        bit e;
        empty_table();
        set_trex(50, 93, 44, 47);
        set_slot(1, 1'b0, 80, 110, 17, 35);
        run_scan(lat);
        e = exp_q.pop_front();
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL invalid_done_latency got %0d want 4", lat); end
        n_vec++; if (crash !== e) begin n_err++; $display("FAIL invalid_crash got %b want %b", crash, e); end
        @(negedge clk);
    endtask

    task automatic test_sticky();
        int lat;
        bit e;
        empty_table();
        set_trex(50, 93, 44, 47);
        set_slot(0, 1'b1, 60, 100, 10, 10);
        run_scan(lat);
        e = exp_q.pop_front();
        n_vec++; if (crash !== e) begin n_err++; $display("FAIL sticky_first_crash got %b want %b", crash, e); end
        @(negedge clk);
        empty_table();
        run_scan(lat);
        e = exp_q.pop_front();
        n_vec++; if (crash !== e) begin n_err++; $display("FAIL sticky_hold got %b want %b", crash, e); end
        @(negedge clk);
        do_clear();
        n_vec++; if (crash !== 1'b0) begin n_err++; $display("FAIL sticky_clear got %b want 0", crash); end
    endtask

    task automatic test_back_to_back();
        bit e, ok;
        empty_table();
        set_trex(50, 93, 44, 47);
        set_slot(1, 1'b1, 80, 110, 17, 35);
        exp_q.push_back(crash_m | model_hit());
        crash_m |= model_hit();
        idx_log.delete();
        done_cnt = 0;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        set_trex(600, 10, 20, 20);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (12) @(negedge clk);
        e = exp_q.pop_front();
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL b2b_done_count got %0d want 1", done_cnt); end
        ok = (idx_log.size() == N);
        for (int i = 0; i < idx_log.size(); i++) if (idx_log[i] != i) ok = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_idx_seq got %p want 0,1,2", idx_log); end
        n_vec++; if (crash !== e) begin n_err++; $display("FAIL b2b_crash got %b want %b", crash, e); end
        do_clear();
    endtask

    task automatic test_clear_mid_scan();
        int lat;
        bit e;
        empty_table();
        set_trex(50, 93, 44, 47);
        set_slot(1, 1'b1, 80, 110, 17, 35);
        done_cnt = 0;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        crash_m = 1'b0;
        n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL clearmid_obs_req got %b want 0", obs_req); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clearmid_busy got %b want 0", busy); end
        repeat (8) @(negedge clk);
        n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL clearmid_done_count got %0d want 0", done_cnt); end
        n_vec++; if (crash !== 1'b0) begin n_err++; $display("FAIL clearmid_crash got %b want 0", crash); end
        run_scan(lat);
        e = exp_q.pop_front();
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL clearmid_rescan_latency got %0d want 4", lat); end
        n_vec++; if (crash !== e) begin n_err++; $display("FAIL clearmid_rescan_crash got %b want %b", crash, e); end
        @(negedge clk);
        do_clear();
    endtask

    task automatic test_clear_with_update();
        empty_table();
        set_trex(50, 93, 44, 47);
        set_slot(0, 1'b1, 60, 100, 10, 10);
        clear = 1'b1;
        update = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        update = 1'b0;
        crash_m = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clrupd_busy got %b want 0", busy); end
        n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL clrupd_obs_req got %b want 0", obs_req); end
        @(negedge clk);
    endtask

    initial begin
        empty_table();
        test_reset();
        test_basic();
        test_edges();
        test_negative();
        test_invalid_slot();
        test_sticky();
        test_back_to_back();
        test_clear_mid_scan();
        test_clear_with_update();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
